data_memory_arbiter: RTL and testbench
======================================

# data_memory_arbiter

Two-requester round-robin arbiter and sequencer in front of the single-write-port / single-read-port `data_memory`. Requester A (Beta CPU datapath) and requester B (game-logic / display refresh engine) each issue single-word read or write transactions. The arbiter grants at most one transaction per cycle, drives the memory ports, and returns read data registered one cycle after the grant. It sits between both requesters and the `data_memory` instance.

## Interface
Parameters:
- `SIZE`, 16, word width; must match `data_memory.SIZE`
- `DEPTH`, 64, number of words; `AW = $clog2(DEPTH)`

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  reset; synchronous and active-high
- `a_req`  in  1  A requests a transaction
- `a_we`  in  1  1 = write, 0 = read
- `a_addr`  in  AW  word address
- `a_wdata`  in  SIZE  write data
- `a_gnt`  out  1  combinational; A's transaction completes at this clock edge
- `a_rvalid`  out  1  registered; A's read data valid this cycle
- `a_rdata`  out  SIZE  registered read data for A
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: same as A, for requester B
- `mem_waddr`  out  AW  to `data_memory.waddr`
- `mem_write_data`  out  SIZE  to `data_memory.write_data`
- `mem_write_en`  out  1  to `data_memory.write_en`
- `mem_raddr`  out  AW  to `data_memory.raddr`
- `mem_read_data`  in  SIZE  from `data_memory.read_data` (combinational read)

## Operation
- State: priority pointer `prio` (0 = A favoured, 1 = B favoured); `a_rvalid`, `b_rvalid`, `a_rdata`, `b_rdata` registers.
- Grant logic (combinational, from `prio` and requests):
  - Only A requests: `a_gnt = 1`. Only B requests: `b_gnt = 1`.
  - Both request: the requester favoured by `prio` is granted.
  - Never both grants at once; no grant while `rst = 1`.
- Pointer update at the edge: on A's grant `prio <= 1`; on B's grant `prio <= 0`; with no grant, `prio` holds. Worst-case wait for a continuously requesting port is 1 cycle.
- Memory drive: the granted requester's `addr` drives both `mem_waddr` and `mem_raddr`. `mem_write_data` carries the granted `wdata`. `mem_write_en = gnt & we`. With no grant, the address and data outputs carry requester A's fields and `mem_write_en = 0`.
- Read return: on a granted read, `x_rdata <= mem_read_data` and `x_rvalid <= 1` at the same edge. The ungranted port's `rvalid` goes to 0. `rdata` holds its value when not updated.
- Requester rule: `req`, `we`, `addr`, `wdata` must be held stable until `gnt` is seen. A new request may be issued in the cycle after `gnt`.
- Writes produce no response; a write is committed at the edge where `gnt` is asserted.

## Timing
- Reset values: `prio = 0`; `a_rvalid = b_rvalid = 0`; `a_rdata = b_rdata = 0`. Combinationally during `rst`: `a_gnt = b_gnt = 0` and `mem_write_en = 0`.
- Grant latency: 0 cycles (same cycle as `req` when the port wins). Read latency: `rvalid` 1 cycle after `gnt`.
- Throughput: 1 transaction per cycle total; back-to-back grants to the same port are allowed when the other port is idle.
- Write then read to the same address in consecutive cycles (either port): the read returns the new data.
- Reset asserted mid-request: the transaction is dropped and nothing is written. The requester still holds `req`, so it is granted on the first cycle after `rst` deasserts, with A favoured.
- `addr` is always in range, since `AW` bits index `DEPTH` entries. If `DEPTH` is not a power of 2, out-of-range addresses are the requester's responsibility.

## Structure
- Shared package `hc_mem_pkg`: the `REQ_A = 0` / `REQ_B = 1` index constants and the `AW` derivation function. `data_memory` and the CPU use these too.
- One sub-module, `rr_arb2`, holds `prio` and produces the two-way grant vector from `req[1:0]`. The top level contains the muxing and the read-return registers.

## Test plan
- Reset: hold `rst` 2 cycles with `a_req = b_req = 1`, `a_we = 1` → no grants, `mem_write_en = 0`, all `rvalid`/`rdata` outputs 0.
- Single port: A writes `0xBEEF` to addr 5, then reads addr 5 in the next cycle → `a_gnt` asserted both cycles, `a_rvalid = 1` with `a_rdata = 0xBEEF` in the third cycle.
- Contention: both ports read continuously for 6 cycles after reset → grants alternate A, B, A, B, A, B. Each `rvalid` pulses in the cycle after its own grant.
- Cross-port coherence: B writes `0x1234` to addr 63 while A requests a read of 63 in the same cycle with A favoured → A is granted first and reads the old value; B writes next cycle; A's next read returns `0x1234`.
- Mid-op reset: B requests a write of `0x00FF` to addr 10 and `rst` is asserted that cycle → no write occurs, and a later read of addr 10 returns the prior contents. After reset, B is granted on the first free cycle.
- Idle: no requests for 4 cycles → `prio` unchanged, `rvalid` stays 0, `rdata` holds its last value.

Source files
------------

// File: rtl/hc_mem_pkg.sv
// hc_mem_pkg
// Shared definitions for the data memory subsystem: requester index
// constants used to pack/unpack per-requester vectors, and the address
// width derivation used by data_memory, the arbiter and the CPU.
package hc_mem_pkg;

    localparam int REQ_A = 0;   // Beta CPU datapath
    localparam int REQ_B = 1;   // game-logic / display refresh engine

    // Address width for a memory of 'depth' words (at least one bit so a
    // single-word memory still has a legal port).
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/data_memory_arbiter_rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter. Holds the priority pointer and turns the
// request vector into a one-hot (or zero) grant vector in the same cycle.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (pointer favours A, no grants)
//   req  - request vector, bit REQ_A / REQ_B
//   gnt  - combinational grant vector, never more than one bit set
module rr_arb2
    import hc_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 0 = A favoured, 1 = B favoured
    logic prio_reg;

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (req[REQ_A] && req[REQ_B]) begin
                gnt[REQ_B] = prio_reg;
                gnt[REQ_A] = ~prio_reg;
            end else begin
                gnt = req;
            end
        end
    end

    // The winner hands priority to the other port; idle cycles keep it.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_reg <= 1'b0;
        end else if (gnt[REQ_A]) begin
            prio_reg <= 1'b1;
        end else if (gnt[REQ_B]) begin
            prio_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
// Round-robin arbiter and sequencer in front of data_memory (one write
// port, one combinational read port). Requesters A and B issue single-word
// reads or writes; at most one is granted per cycle. Writes commit at the
// grant edge, read data is registered and returned one cycle after grant.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata      - requester A transaction (held until gnt)
//   a_gnt                          - combinational grant to A
//   a_rvalid/a_rdata               - registered read return to A
//   b_*                            - same for requester B
//   mem_waddr/mem_write_data/mem_write_en - data_memory write port
//   mem_raddr/mem_read_data        - data_memory read port
module data_memory_arbiter
    import hc_mem_pkg::*;
#(
    parameter int SIZE  = 16,
    parameter int DEPTH = 64,
    localparam int AW   = addr_width(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            a_req,
    input  logic            a_we,
    input  logic [AW-1:0]   a_addr,
    input  logic [SIZE-1:0] a_wdata,
    output logic            a_gnt,
    output logic            a_rvalid,
    output logic [SIZE-1:0] a_rdata,

    input  logic            b_req,
    input  logic            b_we,
    input  logic [AW-1:0]   b_addr,
    input  logic [SIZE-1:0] b_wdata,
    output logic            b_gnt,
    output logic            b_rvalid,
    output logic [SIZE-1:0] b_rdata,

    output logic [AW-1:0]   mem_waddr,
    output logic [SIZE-1:0] mem_write_data,
    output logic            mem_write_en,
    output logic [AW-1:0]   mem_raddr,
    input  logic [SIZE-1:0] mem_read_data
);

    logic [1:0]            req_vec;
    logic [1:0]            gnt_vec;
    logic [1:0]            we_vec;
    logic [1:0]            rvalid_reg;
    logic [1:0][SIZE-1:0]  rdata_reg;
    logic                  sel_b;

    assign req_vec[REQ_A] = a_req;
    assign req_vec[REQ_B] = b_req;
    assign we_vec[REQ_A]  = a_we;
    assign we_vec[REQ_B]  = b_we;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_vec),
        .gnt (gnt_vec)
    );

    assign a_gnt = gnt_vec[REQ_A];
    assign b_gnt = gnt_vec[REQ_B];

    // B steers the memory only when granted; otherwise A's fields sit on
    // the ports so the address mux is a single select bit.
    assign sel_b          = gnt_vec[REQ_B];
    assign mem_waddr      = sel_b ? b_addr  : a_addr;
    assign mem_raddr      = sel_b ? b_addr  : a_addr;
    assign mem_write_data = sel_b ? b_wdata : a_wdata;
    assign mem_write_en   = |(gnt_vec & we_vec);

    // Read return: the grant edge captures the combinational read data, so
    // a write granted in the previous cycle is already visible here.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_reg <= 2'b00;
            rdata_reg  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rvalid_reg[i] <= gnt_vec[i] & ~we_vec[i];
                if (gnt_vec[i] && !we_vec[i]) begin
                    rdata_reg[i] <= mem_read_data;
                end
            end
        end
    end

    assign a_rvalid = rvalid_reg[REQ_A];
    assign a_rdata  = rdata_reg[REQ_A];
    assign b_rvalid = rvalid_reg[REQ_B];
    assign b_rdata  = rdata_reg[REQ_B];

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;

    localparam int SIZE  = 16;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            a_req, a_we, b_req, b_we;
    logic [AW-1:0]   a_addr, b_addr;
    logic [SIZE-1:0] a_wdata, b_wdata;
    logic            a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [SIZE-1:0] a_rdata, b_rdata;
    logic [AW-1:0]   mem_waddr, mem_raddr;
    logic [SIZE-1:0] mem_write_data, mem_read_data;
    logic            mem_write_en;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_memory_arbiter #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_waddr(mem_waddr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_raddr(mem_raddr),
        .mem_read_data(mem_read_data)
    );

    // Stand-in for data_memory: combinational read, write at the edge.
    logic [SIZE-1:0] mem [DEPTH];
    assign mem_read_data = mem[mem_raddr];
    always @(posedge clk) if (mem_write_en) mem[mem_waddr] <= mem_write_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [SIZE-1:0] ref_mem [DEPTH];
    bit              m_prio;          // which port wins a tie next
    bit              m_a_rv, m_b_rv;
    logic [SIZE-1:0] m_a_rd, m_b_rd;
    bit              chk_en = 0;
    bit              ga, gb;

    always @(negedge clk) begin
        if (chk_en) begin
            ga = !rst && a_req && (!b_req || !m_prio);
            gb = !rst && b_req && (!a_req ||  m_prio);
            chk("a_gnt", a_gnt, ga);
            chk("b_gnt", b_gnt, gb);
            chk("mem_write_en", mem_write_en, (ga && a_we) || (gb && b_we));
            chk("mem_waddr", mem_waddr, gb ? b_addr : a_addr);
            chk("mem_raddr", mem_raddr, gb ? b_addr : a_addr);
            chk("mem_write_data", mem_write_data, gb ? b_wdata : a_wdata);
            chk("a_rvalid", a_rvalid, m_a_rv);
            chk("a_rdata", a_rdata, m_a_rd);
            chk("b_rvalid", b_rvalid, m_b_rv);
            chk("b_rdata", b_rdata, m_b_rd);
            // state after the coming edge
            if (rst) begin
                m_prio = 0; m_a_rv = 0; m_b_rv = 0; m_a_rd = '0; m_b_rd = '0;
            end else begin
                m_a_rv = ga && !a_we;
                m_b_rv = gb && !b_we;
                if (m_a_rv) m_a_rd = ref_mem[a_addr];
                if (m_b_rv) m_b_rd = ref_mem[b_addr];
                if (ga && a_we) ref_mem[a_addr] = a_wdata;
                if (gb && b_we) ref_mem[b_addr] = b_wdata;
                if (ga) m_prio = 1;
                else if (gb) m_prio = 0;
            end
        end
    end

    task automatic edge_t(); @(posedge clk); #1; endtask
    task automatic neg_t();  @(negedge clk);     endtask

    bit a_gnt_s, b_gnt_s;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 16'(i * 257) ^ 16'h5a5a;
            ref_mem[i] = 16'(i * 257) ^ 16'h5a5a;
        end
        rst = 1; a_req = 1; b_req = 1; a_we = 1; b_we = 1;
        a_addr = 0; b_addr = 0; a_wdata = 16'h1111; b_wdata = 16'h2222;

        // Reset held 2 cycles with both writes pending
        edge_t();
        chk_en = 1;
        for (int k = 0; k < 2; k++) begin
            neg_t();
            chk("rst_a_gnt", a_gnt, 0);
            chk("rst_b_gnt", b_gnt, 0);
            chk("rst_wen", mem_write_en, 0);
            chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
            chk("rst_rdata", {a_rdata, b_rdata}, 0);
            edge_t();
        end
        rst = 0; a_req = 0; b_req = 0;

        // Single port: write BEEF to 5, then read it back
        a_req = 1; a_we = 1; a_addr = 5; a_wdata = 16'hBEEF;
        neg_t(); chk("sp_wr_gnt", a_gnt, 1); chk("sp_wen", mem_write_en, 1);
        edge_t();
        a_we = 0;
        neg_t(); chk("sp_rd_gnt", a_gnt, 1);
        edge_t();
        a_req = 0;
        neg_t(); chk("sp_rvalid", a_rvalid, 1); chk("sp_rdata", a_rdata, 16'hBEEF);
        edge_t();

        // Contention after reset: alternate A,B,A,B,A,B
        rst = 1;
        edge_t();
        rst = 0; a_req = 1; a_we = 0; a_addr = 1; b_req = 1; b_we = 0; b_addr = 2;
        for (int k = 0; k < 6; k++) begin
            neg_t();
            chk("ct_a_gnt", a_gnt, (k % 2) == 0);
            chk("ct_b_gnt", b_gnt, (k % 2) == 1);
            chk("ct_a_rvalid", a_rvalid, (k % 2) == 1);
            chk("ct_b_rvalid", b_rvalid, k > 0 && (k % 2) == 0);
            edge_t();
        end
        a_req = 0; b_req = 0;

        // Cross-port coherence on addr 63, A favoured
        a_req = 1; a_we = 0; a_addr = 63;
        b_req = 1; b_we = 1; b_addr = 63; b_wdata = 16'h1234;
        neg_t(); chk("cp_a_first", a_gnt, 1); chk("cp_b_wait", b_gnt, 0);
        edge_t();
        a_req = 0;
        neg_t(); chk("cp_b_gnt", b_gnt, 1); chk("cp_old", a_rdata, 16'h6565);
        edge_t();
        b_req = 0; a_req = 1;
        neg_t(); chk("cp_a_gnt2", a_gnt, 1);
        edge_t();
        a_req = 0;
        neg_t(); chk("cp_new", a_rdata, 16'h1234);
        edge_t();

        // Mid-op reset: B write to 10 dropped
        b_req = 1; b_we = 1; b_addr = 10; b_wdata = 16'h00FF; rst = 1;
        neg_t(); chk("mr_no_gnt", b_gnt, 0); chk("mr_no_wen", mem_write_en, 0);
        edge_t();
        rst = 0; b_req = 0;
        a_req = 1; a_we = 0; a_addr = 10;
        neg_t(); chk("mr_a_gnt", a_gnt, 1);
        edge_t();
        a_req = 0; b_req = 1; b_we = 0; b_addr = 10;
        neg_t(); chk("mr_b_gnt", b_gnt, 1); chk("mr_a_old", a_rdata, 16'h5050);
        edge_t();
        b_req = 0; a_req = 1;
        neg_t(); chk("mr_b_old", b_rdata, 16'h5050);
        edge_t();
        a_req = 0;

        // Idle 4 cycles: B favoured before and after
        for (int k = 0; k < 4; k++) begin
            neg_t();
            if (k > 0) chk("id_a_rvalid", a_rvalid, 0);
            chk("id_b_rvalid", b_rvalid, 0);
            chk("id_a_rdata", a_rdata, 16'h5050);
            chk("id_b_rdata", b_rdata, 16'h5050);
            edge_t();
        end
        a_req = 1; b_req = 1; a_we = 0; b_we = 0;
        neg_t(); chk("id_prio_b", b_gnt, 1);
        edge_t();
        a_req = 0; b_req = 0;

        // Randomized traffic with protocol-abiding requesters
        for (int c = 0; c < 3000; c++) begin
            neg_t();
            a_gnt_s = a_gnt; b_gnt_s = b_gnt;
            edge_t();
            rst = ($urandom_range(0, 63) == 0);
            if (!a_req || a_gnt_s) begin
                a_req = ($urandom_range(0, 3) != 0);
                a_we = $urandom_range(0, 1); a_addr = AW'($urandom_range(0, 7));
                a_wdata = SIZE'($urandom);
            end
            if (!b_req || b_gnt_s) begin
                b_req = ($urandom_range(0, 3) != 0);
                b_we = $urandom_range(0, 1); b_addr = AW'($urandom_range(0, 7));
                b_wdata = SIZE'($urandom);
            end
        end
        rst = 0; a_req = 0; b_req = 0;
        neg_t();
        edge_t();
        neg_t();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
